// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_pkg
// Description : Op-code constants, controller state encoding and op helpers
//               shared by the bit-serial ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NOTA  = 3'b010;
    localparam logic [2:0] OP_NOTB  = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_ORNB  = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_ANDNB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Only add and subtract propagate a carry through the slice.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_ctrl_if
// Description : Request/result bus and external 1-bit slice connection of the
//               serial ALU controller. ovf exists only with SERIAL_ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_alu_ctrl_if #(
    parameter int W = 16
);

    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif
    logic [2:0]   sl_c;
    logic         sl_ai;
    logic         sl_bi;
    logic         sl_ci;
    logic         sl_f;
    logic         sl_co;

    modport slave (
`ifdef SERIAL_ALU_OVF_EN
        output ovf,
`endif
        input  start, op, a, b, sl_f, sl_co,
        output busy, done, result, cout, sl_c, sl_ai, sl_bi, sl_ci
    );

    modport master (
`ifdef SERIAL_ALU_OVF_EN
        input  ovf,
`endif
        output start, op, a, b, sl_f, sl_co,
        input  busy, done, result, cout, sl_c, sl_ai, sl_bi, sl_ci
    );

endinterface
`default_nettype wire

// File: rtl/serial_shreg.sv
`default_nettype none
// ============================================================================
// Module      : serial_shreg
// Description : W-bit register with parallel load and 1-bit right shift
//               (serial input enters at the MSB). Load wins over shift.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shreg #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_load,
    input  wire logic         i_shift,
    input  wire logic [W-1:0] i_data,
    input  wire logic         i_sin,
    output logic      [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_ctrl
// Description : Bit-serial ALU controller sequencing an external 1-bit slice,
//               LSB first, over W cycles. Define SERIAL_ALU_OVF_EN for ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_ctrl #(
    parameter int W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_alu_ctrl_if.slave bus
);

    import serial_alu_pkg::*;

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;
    logic            w_run;
    logic            w_last;
    logic            w_arith;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_carry;
    logic [W-1:0]    w_a_q;
    logic [W-1:0]    w_b_q;
    logic [W-1:0]    w_res_q;
    logic            w_unused_ops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_run   = (r_state == ST_RUN);
    assign w_last  = w_run && (r_cnt == CW'(W - 1));
    assign w_arith = op_is_arith(r_op);

    // Subtract is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= 3'b000;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= bus.op;
            r_carry <= (bus.op == OP_SUB);
        end else if (w_run) begin
            r_cnt   <= r_cnt + 1'b1;
            r_carry <= w_arith & bus.sl_co;
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic r_ovf;

    // On the final bit r_carry is the carry into the MSB and sl_co the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_arith & (r_carry ^ bus.sl_co);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    serial_shreg #(.W(W)) u_sh_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_data  (bus.a),
        .i_sin   (1'b0),
        .o_q     (w_a_q)
    );

    serial_shreg #(.W(W)) u_sh_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_data  (bus.b),
        .i_sin   (1'b0),
        .o_q     (w_b_q)
    );

    serial_shreg #(.W(W)) u_sh_res (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_data  ({W{1'b0}}),
        .i_sin   (bus.sl_f),
        .o_q     (w_res_q)
    );

    assign w_unused_ops = ^{w_a_q[W-1:1], w_b_q[W-1:1]};

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = w_res_q;
    assign bus.cout   = r_carry;
    assign bus.sl_c   = r_op;
    assign bus.sl_ai  = w_run & w_a_q[0];
    assign bus.sl_bi  = w_run & w_b_q[0];
    assign bus.sl_ci  = w_run & w_arith & r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_ctrl
// Description : Self-checking bench for serial_alu_ctrl at W=8 with a
//               behavioural 1-bit slice. Honours SERIAL_ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_alu_ctrl_if #(.W(W)) bus ();

    serial_alu_ctrl #(.W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: full adder for add/sub, bitwise function otherwise.
    always_comb begin
        bus.sl_f  = 1'b0;
        bus.sl_co = 1'b0;
        case (bus.sl_c)
            3'b000: begin
                bus.sl_f  = bus.sl_ai ^ bus.sl_bi ^ bus.sl_ci;
                bus.sl_co = (bus.sl_ai & bus.sl_bi) | (bus.sl_ci & (bus.sl_ai ^ bus.sl_bi));
            end
            3'b001: begin
                bus.sl_f  = bus.sl_ai ^ ~bus.sl_bi ^ bus.sl_ci;
                bus.sl_co = (bus.sl_ai & ~bus.sl_bi) | (bus.sl_ci & (bus.sl_ai ^ ~bus.sl_bi));
            end
            3'b010:  bus.sl_f = ~bus.sl_ai;
            3'b011:  bus.sl_f = ~bus.sl_bi;
            3'b100:  bus.sl_f = bus.sl_ai | bus.sl_bi;
            3'b101:  bus.sl_f = bus.sl_ai | ~bus.sl_bi;
            3'b110:  bus.sl_f = bus.sl_ai & bus.sl_bi;
            default: bus.sl_f = bus.sl_ai & ~bus.sl_bi;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ovf_val();
`ifdef SERIAL_ALU_OVF_EN
        return {31'd0, bus.ovf};
`else
        return 32'd0;
`endif
    endfunction

    task automatic run_op(input vec_t v, input string name);
        int   n;
        bit   seen;
        bit   logic_bad;
        logic arith;
        arith = (v.op == 3'b000) || (v.op == 3'b001);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~v.a;
        bus.b     = ~v.b;
        n         = 1;
        seen      = 1'b0;
        logic_bad = 1'b0;
        while (!seen && n <= 3 * W) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (!arith && (bus.sl_ci || bus.cout)) logic_bad = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        check({name, " done_seen"}, {31'd0, seen}, 32'd1);
        check({name, " latency"}, n, W + 1);
        check({name, " result"}, bus.result, v.res);
        check({name, " cout"}, bus.cout, v.co);
`ifdef SERIAL_ALU_OVF_EN
        check({name, " ovf"}, ovf_val(), {31'd0, v.ov});
`endif
        if (!arith) check({name, " logic_ci_cout_zero"}, {31'd0, logic_bad}, 32'd0);
        @(negedge clk);
        check({name, " done_single"}, {31'd0, bus.done}, 32'd0);
        check({name, " idle_slice"}, {bus.sl_c, bus.sl_ai, bus.sl_bi, bus.sl_ci}, {v.op, 3'b000});
        @(negedge clk);
        check({name, " result_hold"}, {bus.cout, bus.result}, {v.co, v.res});
    endtask

    initial begin : main
        vec_t vecs[12];
        vec_t v;
        int   n;
        int   cnt;
        int   first;
        int   times[8];

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0]  = '{3'b000, 8'h3C, 8'h47, 8'h83, 1'b0, 1'b1};
        vecs[1]  = '{3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};
        vecs[2]  = '{3'b010, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[3]  = '{3'b110, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[7]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{3'b011, 8'h00, 8'h3C, 8'hC3, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0};
        vecs[11] = '{3'b111, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.cout, bus.sl_ai, bus.sl_bi, bus.sl_ci, bus.sl_c, bus.result},
              32'd0);
        check("reset_ovf", ovf_val(), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed mid-operation with different operands must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h3C; bus.b = 8'h47;
        cnt = 0; first = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.start = (n == 3);
            if (n == 3) begin bus.a = 8'h11; bus.b = 8'h22; end
            if (bus.done) begin
                cnt++;
                if (first == 0) begin
                    first = n;
                    check("midstart_result", bus.result, 32'h83);
                end
            end
        end
        bus.start = 1'b0;
        check("midstart_done_count", cnt, 1);
        check("midstart_latency", first, W + 1);

        // reset dropped in the 4th RUN cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 8'h34; bus.b = 8'h12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {bus.busy, bus.done, bus.cout, bus.sl_ai, bus.sl_bi, bus.sl_ci, bus.sl_c, bus.result},
              32'd0);
        check("abort_ovf", ovf_val(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) cnt++;
        end
        check("abort_no_done", cnt, 0);
        v = '{3'b001, 8'h34, 8'h12, 8'h22, 1'b1, 1'b0};
        run_op(v, "after_abort");

        // start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 8'h10; bus.b = 8'h01;
        cnt = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (cnt < 8) times[cnt] = n;
                cnt++;
                check("held_result", bus.result, 32'h0F);
            end
        end
        bus.start = 1'b0;
        check("held_done_count", cnt, 4);
        if (cnt >= 1) check("held_first", times[0], W + 1);
        for (int k = 1; k < 4 && k < cnt; k++) begin
            check($sformatf("held_spacing%0d", k), times[k] - times[k-1], W + 2);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
